hazard_stall_ctrl: RTL and testbench

//  Pipeline sequencing controller for the decode stage. Holds a per-register

---
 rtl/hazard_stall_ctrl.sv | 143 ++++++++++++++
 tb/tb_hazard_stall_ctrl.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_stall_ctrl.sv
// hazard_stall_ctrl
//   Decode-stage sequencing controller. Keeps a per-register busy scoreboard,
//   stalls IF/ID and bubbles EX on RAW/WAW hazards, and holds flush_if/flush_id
//   high for FLUSH_CYCLES cycles after a taken branch.
//
//   Optional build macro: HAZARD_WB_BYPASS_EN -- a writeback in the same cycle
//   resolves the hazard on that register. The register file must then forward
//   write data to its read ports.
//
// Ports
//   clk, reset                    clock, synchronous active-high reset
//   id_valid                      decode holds a valid instruction
//   id_src{1,2}_idx/_use          source operands and their read enables
//   id_dest_idx/id_dest_wr        destination and its write enable
//   wb_valid/wb_idx               writeback commit
//   branch_taken                  taken branch resolved in EX (1-cycle pulse)
//   issue                         decode instruction advances to EX
//   stall_if/stall_id/bubble_ex   hazard stall controls
//   flush_if/flush_id             squash IF/ID registers
//   busy_vec                      registered scoreboard
//   stall_count                   saturating hazard-stall cycle count
module hazard_stall_ctrl #(
  parameter int NUM_REGS     = 32,
  parameter int IDX_W        = 5,
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                id_valid,
  input  logic [IDX_W-1:0]    id_src1_idx,
  input  logic                id_src1_use,
  input  logic [IDX_W-1:0]    id_src2_idx,
  input  logic                id_src2_use,
  input  logic [IDX_W-1:0]    id_dest_idx,
  input  logic                id_dest_wr,
  input  logic                wb_valid,
  input  logic [IDX_W-1:0]    wb_idx,
  input  logic                branch_taken,
  output logic                issue,
  output logic                stall_if,
  output logic                stall_id,
  output logic                bubble_ex,
  output logic                flush_if,
  output logic                flush_id,
  output logic [NUM_REGS-1:0] busy_vec,
  output logic [CNT_W-1:0]    stall_count
);

  localparam int FC_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [FC_W-1:0] FC_LOAD = FC_W'(FLUSH_CYCLES - 1);

  typedef enum logic {IDLE, FLUSH} state_e;

  state_e              state_q, state_d;
  logic [FC_W-1:0]     fcnt_q, fcnt_d;
  logic [NUM_REGS-1:0] busy_q, busy_d;
  logic [CNT_W-1:0]    scnt_q, scnt_d;

  logic [NUM_REGS-1:0] wb_dec, busy_eff, set_vec;
  logic                hazard, flushing;

  // One-hot decode of a register index; out-of-range indices decode to zero.
  function automatic logic [NUM_REGS-1:0] idx_dec(input logic [IDX_W-1:0] idx);
    idx_dec = '0;
    for (int i = 0; i < NUM_REGS; i++)
      if (idx == IDX_W'(i)) idx_dec[i] = 1'b1;
  endfunction

  always_comb begin
    wb_dec = wb_valid ? idx_dec(wb_idx) : '0;
`ifdef HAZARD_WB_BYPASS_EN
    busy_eff = busy_q & ~wb_dec;
`else
    busy_eff = busy_q;
`endif
    // busy_q[0] is never set, so r0 can never raise a hazard.
    hazard = id_valid & ((id_src1_use & |(busy_eff & idx_dec(id_src1_idx))) |
                         (id_src2_use & |(busy_eff & idx_dec(id_src2_idx))) |
                         (id_dest_wr  & |(busy_eff & idx_dec(id_dest_idx))));
    flushing  = (state_q == FLUSH) | branch_taken;
    stall_if  = hazard & ~flushing;
    stall_id  = stall_if;
    bubble_ex = stall_if;
    issue     = id_valid & ~hazard & ~flushing;
    flush_if  = flushing;
    flush_id  = flushing;
    busy_vec    = busy_q;
    stall_count = scnt_q;
  end

  // Scoreboard next state: clear on writeback, then set on issue (set wins).
  always_comb begin
    set_vec    = (issue & id_dest_wr) ? idx_dec(id_dest_idx) : '0;
    set_vec[0] = 1'b0;
    busy_d     = (busy_q & ~wb_dec) | set_vec;
    scnt_d     = (stall_id && !(&scnt_q)) ? scnt_q + 1'b1 : scnt_q;
  end

  // Flush sequencer. The branch cycle itself is the first flush cycle, so
  // FLUSH holds fcnt_q = remaining extra cycles and leaves when it hits 1.
  always_comb begin
    state_d = state_q;
    fcnt_d  = fcnt_q;
    case (state_q)
      IDLE: begin
        if (branch_taken && FLUSH_CYCLES > 1) begin
          state_d = FLUSH;
          fcnt_d  = FC_LOAD;
        end
      end
      FLUSH: begin
        if (branch_taken) begin
          fcnt_d = FC_LOAD;
        end else if (fcnt_q <= FC_W'(1)) begin
          state_d = IDLE;
          fcnt_d  = '0;
        end else begin
          fcnt_d = fcnt_q - 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        fcnt_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      fcnt_q  <= '0;
      busy_q  <= '0;
      scnt_q  <= '0;
    end else begin
      state_q <= state_d;
      fcnt_q  <= fcnt_d;
      busy_q  <= busy_d;
      scnt_q  <= scnt_d;
    end
  end

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
module tb_hazard_stall_ctrl;
  localparam int NR = 32;
  localparam int IW = 5;
  localparam int FC = 2;
`ifdef HAZARD_WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  typedef struct {
    logic rst, idv, s1u, s2u, dw, wbv, br;
    logic [IW-1:0] s1, s2, d, wbi;
  } vec_t;

  typedef struct {
    vec_t in;
    logic ei, es, ef;
    int   bidx;
    logic bval;
  } row_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset, id_valid, id_src1_use, id_src2_use, id_dest_wr, wb_valid, branch_taken;
  logic [IW-1:0] id_src1_idx, id_src2_idx, id_dest_idx, wb_idx;
  logic issue, stall_if, stall_id, bubble_ex, flush_if, flush_id;
  logic issue4, stall_if4, stall_id4, bubble_ex4, flush_if4, flush_id4;
  logic [NR-1:0] busy_vec, busy_vec4;
  logic [15:0] stall_count;
  logic [3:0]  stall_count4;

  hazard_stall_ctrl #(.NUM_REGS(NR), .IDX_W(IW), .FLUSH_CYCLES(FC), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .id_valid(id_valid),
    .id_src1_idx(id_src1_idx), .id_src1_use(id_src1_use),
    .id_src2_idx(id_src2_idx), .id_src2_use(id_src2_use),
    .id_dest_idx(id_dest_idx), .id_dest_wr(id_dest_wr),
    .wb_valid(wb_valid), .wb_idx(wb_idx), .branch_taken(branch_taken),
    .issue(issue), .stall_if(stall_if), .stall_id(stall_id), .bubble_ex(bubble_ex),
    .flush_if(flush_if), .flush_id(flush_id), .busy_vec(busy_vec), .stall_count(stall_count));

  hazard_stall_ctrl #(.NUM_REGS(NR), .IDX_W(IW), .FLUSH_CYCLES(FC), .CNT_W(4)) dut4 (
    .clk(clk), .reset(reset), .id_valid(id_valid),
    .id_src1_idx(id_src1_idx), .id_src1_use(id_src1_use),
    .id_src2_idx(id_src2_idx), .id_src2_use(id_src2_use),
    .id_dest_idx(id_dest_idx), .id_dest_wr(id_dest_wr),
    .wb_valid(wb_valid), .wb_idx(wb_idx), .branch_taken(branch_taken),
    .issue(issue4), .stall_if(stall_if4), .stall_id(stall_id4), .bubble_ex(bubble_ex4),
    .flush_if(flush_if4), .flush_id(flush_id4), .busy_vec(busy_vec4), .stall_count(stall_count4));

  int n_cmp = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  // Reference model: architectural view of the scoreboard and flush window.
  bit mbusy[NR];
  int mflush;      // flush cycles still owed after the current one
  int mcnt, mcnt4;
  bit m_issue, m_stall, m_flush;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit mB(int i, vec_t v);
    return (i != 0) && mbusy[i] && !(BYP && v.wbv && (int'(v.wbi) == i));
  endfunction

  function automatic vec_t idle();
    vec_t v;
    v.rst = 0; v.idv = 0; v.s1u = 0; v.s2u = 0; v.dw = 0; v.wbv = 0; v.br = 0;
    v.s1 = 0; v.s2 = 0; v.d = 0; v.wbi = 0;
    return v;
  endfunction

  task automatic drive_check(input vec_t v);
    logic [NR-1:0] eb;
    bit hz;
    @(negedge clk);
    reset = v.rst; id_valid = v.idv; id_src1_idx = v.s1; id_src1_use = v.s1u;
    id_src2_idx = v.s2; id_src2_use = v.s2u; id_dest_idx = v.d; id_dest_wr = v.dw;
    wb_valid = v.wbv; wb_idx = v.wbi; branch_taken = v.br;
    #1;
    m_flush = v.br || (mflush > 0);
    hz = v.idv && ((v.s1u && mB(int'(v.s1), v)) || (v.s2u && mB(int'(v.s2), v)) ||
                   (v.dw && mB(int'(v.d), v)));
    m_stall = hz && !m_flush;
    m_issue = v.idv && !hz && !m_flush;
    for (int i = 0; i < NR; i++) eb[i] = mbusy[i];
    if (chk_en) begin
      chk("issue", issue, m_issue);
      chk("stall_if", stall_if, m_stall);
      chk("stall_id", stall_id, m_stall);
      chk("bubble_ex", bubble_ex, m_stall);
      chk("flush_if", flush_if, m_flush);
      chk("flush_id", flush_id, m_flush);
      chk("busy_vec", busy_vec, eb);
      chk("stall_count", stall_count, mcnt);
      chk("stall_count_w4", stall_count4, mcnt4);
    end
  endtask

  task automatic tick(input vec_t v);
    @(posedge clk);
    if (v.rst) begin
      foreach (mbusy[i]) mbusy[i] = 0;
      mflush = 0; mcnt = 0; mcnt4 = 0;
    end else begin
      if (v.wbv) mbusy[v.wbi] = 0;
      if (m_issue && v.dw && v.d != 0) mbusy[v.d] = 1;
      mflush = v.br ? FC - 1 : (mflush > 0 ? mflush - 1 : 0);
      if (m_stall) begin
        if (mcnt < 65535) mcnt++;
        if (mcnt4 < 15) mcnt4++;
      end
    end
  endtask

  task automatic step(input vec_t v);
    drive_check(v);
    tick(v);
  endtask

  function automatic row_t R(bit idv, int s1, bit s1u, int s2, bit s2u, int d, bit dw,
                             bit wbv, int wbi, bit br, bit ei, bit es, bit ef,
                             int bidx, bit bval);
    row_t r;
    r.in = idle();
    r.in.idv = idv; r.in.s1 = IW'(s1); r.in.s1u = s1u; r.in.s2 = IW'(s2); r.in.s2u = s2u;
    r.in.d = IW'(d); r.in.dw = dw; r.in.wbv = wbv; r.in.wbi = IW'(wbi); r.in.br = br;
    r.ei = ei; r.es = es; r.ef = ef; r.bidx = bidx; r.bval = bval;
    return r;
  endfunction

  row_t tbl[27];
  vec_t v;

  initial begin
    // RAW on r3 (src1 then src2)
    tbl[0]  = R(0,0,0,0,0,0,0,0,0,0, 0,0,0, 3,0);
    tbl[1]  = R(1,0,0,0,0,3,1,0,0,0, 1,0,0, 3,0);
    tbl[2]  = R(1,3,1,0,0,0,0,0,0,0, 0,1,0, 3,1);
    tbl[3]  = R(1,0,0,3,1,0,0,0,0,0, 0,1,0, 3,1);
    tbl[4]  = R(1,3,1,0,0,0,0,1,3,0, BYP,!BYP,0, 3,1);
    tbl[5]  = R(1,3,1,0,0,0,0,0,0,0, 1,0,0, 3,0);
    // WAW on r5
    tbl[6]  = R(1,0,0,0,0,5,1,0,0,0, 1,0,0, 5,0);
    tbl[7]  = R(1,0,0,0,0,5,1,0,0,0, 0,1,0, 5,1);
    tbl[8]  = R(1,0,0,0,0,5,1,1,5,0, BYP,!BYP,0, 5,1);
    tbl[9]  = R(0,0,0,0,0,0,0,0,0,0, 0,0,0, 5,BYP);
    tbl[10] = R(0,0,0,0,0,0,0,1,5,0, 0,0,0, 5,BYP);
    // r0 never busy, never a hazard
    tbl[11] = R(1,0,0,0,0,0,1,0,0,0, 1,0,0, 5,0);
    tbl[12] = R(1,0,1,0,0,0,0,0,0,0, 1,0,0, 0,0);
    // same-cycle set and clear on r7: set wins
    tbl[13] = R(1,0,0,0,0,7,1,1,7,0, 1,0,0, 7,0);
    tbl[14] = R(0,0,0,0,0,0,0,0,0,0, 0,0,0, 7,1);
    tbl[15] = R(0,0,0,0,0,0,0,1,7,0, 0,0,0, 7,1);
    tbl[16] = R(0,0,0,0,0,0,0,0,0,0, 0,0,0, 7,0);
    // branch over a pending hazard on r9
    tbl[17] = R(1,0,0,0,0,9,1,0,0,0, 1,0,0, 9,0);
    tbl[18] = R(1,9,1,0,0,0,0,0,0,1, 0,0,1, 9,1);
    tbl[19] = R(1,9,1,0,0,0,0,0,0,0, 0,0,1, 9,1);
    tbl[20] = R(1,9,1,0,0,0,0,0,0,0, 0,1,0, 9,1);
    tbl[21] = R(0,0,0,0,0,0,0,1,9,0, 0,0,0, 9,1);
    tbl[22] = R(0,0,0,0,0,0,0,0,0,0, 0,0,0, 9,0);
    // branch during flush restarts the window
    tbl[23] = R(0,0,0,0,0,0,0,0,0,1, 0,0,1, 9,0);
    tbl[24] = R(0,0,0,0,0,0,0,0,0,1, 0,0,1, 0,0);
    tbl[25] = R(0,0,0,0,0,0,0,0,0,0, 0,0,1, 0,0);
    tbl[26] = R(0,0,0,0,0,0,0,0,0,0, 0,0,0, 0,0);

    foreach (mbusy[i]) mbusy[i] = 0;
    mflush = 0; mcnt = 0; mcnt4 = 0;
    v = idle(); v.rst = 1;
    step(v); step(v);
    chk_en = 1'b1;

    // reset state
    v = idle(); v.rst = 1;
    drive_check(v);
    chk("reset_busy", busy_vec, '0);
    chk("reset_count", stall_count, 16'd0);
    chk("reset_flush", flush_if, 1'b0);
    tick(v);

    for (int i = 0; i < $size(tbl); i++) begin
      drive_check(tbl[i].in);
      chk($sformatf("tbl%0d_issue", i), issue, tbl[i].ei);
      chk($sformatf("tbl%0d_stall", i), stall_id, tbl[i].es);
      chk($sformatf("tbl%0d_flush", i), flush_id, tbl[i].ef);
      chk($sformatf("tbl%0d_busy", i), busy_vec[tbl[i].bidx], tbl[i].bval);
      tick(tbl[i].in);
    end

    // Reset mid-flush with stall_count = 5
    v = idle(); v.rst = 1; step(v);
    v = idle(); v.idv = 1; v.d = 4; v.dw = 1; step(v);
    v = idle(); v.idv = 1; v.s1 = 4; v.s1u = 1;
    for (int i = 0; i < 5; i++) step(v);
    v = idle(); drive_check(v);
    chk("seq_count5", stall_count, 16'd5);
    tick(v);
    v = idle(); v.br = 1; step(v);
    v = idle(); v.rst = 1; drive_check(v);
    chk("seq_flush_cyc", flush_if, 1'b1);
    tick(v);
    v = idle(); drive_check(v);
    chk("seq_rst_flush_if", flush_if, 1'b0);
    chk("seq_rst_flush_id", flush_id, 1'b0);
    chk("seq_rst_busy", busy_vec, '0);
    chk("seq_rst_count", stall_count, 16'd0);
    tick(v);

    // Saturation of the 4-bit counter: 20 stall cycles
    v = idle(); v.idv = 1; v.d = 4; v.dw = 1; step(v);
    v = idle(); v.idv = 1; v.s1 = 4; v.s1u = 1;
    for (int i = 0; i < 20; i++) step(v);
    v = idle(); drive_check(v);
    chk("sat_w4", stall_count4, 4'd15);
    chk("sat_w16", stall_count, 16'd20);
    tick(v);

    // Randomized run against the model
    for (int n = 0; n < 3000; n++) begin
      v = idle();
      v.rst = ($urandom_range(0, 199) == 0);
      v.idv = ($urandom_range(0, 3) != 0);
      v.s1 = IW'($urandom_range(0, 7)); v.s1u = $urandom_range(0, 1);
      v.s2 = IW'($urandom_range(0, 7)); v.s2u = $urandom_range(0, 1);
      v.d  = IW'($urandom_range(0, 7)); v.dw  = $urandom_range(0, 1);
      v.wbv = ($urandom_range(0, 2) == 0); v.wbi = IW'($urandom_range(0, 7));
      v.br = ($urandom_range(0, 15) == 0);
      step(v);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
